// File: rtl/mul_issue_ctrl.sv
// Issue controller for an external LAT-cycle 4x4 multiplier with a credit-guarded, in-order result FIFO.
// Optional running product accumulator is built only when MUL_ISSUE_ACC_EN is defined.
module mul_issue_ctrl #(
  parameter int LAT   = 4,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_a,
  input  logic [3:0]  in_b,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  input  logic [7:0]  mul_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_p,
  output logic [3:0]  inflight,
  output logic [11:0] acc,
  input  logic        acc_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic           accept;
  logic           capture;
  logic           pop;
  logic [LAT-1:0] vpipe;
  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [3:0]     inflight_q;
  logic [5:0]     credit_used;

  // Every issued product already owns a FIFO slot, so a capture can never find the FIFO full.
  assign credit_used = 6'(count) + 6'(inflight_q);
  assign in_ready    = rst_n && (credit_used < 6'(DEPTH));
  assign accept      = in_valid && in_ready;
  assign capture     = vpipe[LAT-1];
  assign out_valid   = (count != '0);
  assign pop         = out_valid && out_ready;
  assign out_p       = out_valid ? mem[rd_ptr] : 8'd0;
  assign inflight    = inflight_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a <= '0;
      mul_b <= '0;
    end else if (accept) begin
      mul_a <= in_a;
      mul_b <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe <= '0;
    end else begin
      vpipe <= (vpipe << 1) | LAT'(accept);
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      mem[wr_ptr] <= mul_p;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (capture) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({capture, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
    end else begin
      case ({accept, capture})
        2'b10:   inflight_q <= inflight_q + 4'd1;
        2'b01:   inflight_q <= inflight_q - 4'd1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

`ifdef MUL_ISSUE_ACC_EN
  // Clear wins over an add landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (capture) begin
      acc <= acc + {4'd0, mul_p};
    end
  end
`else
  logic unused_acc_clr;
  assign unused_acc_clr = acc_clr;
  assign acc = '0;
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(capture && !pop && (count == CW'(DEPTH))));
    end
  end
`endif

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a behavioural LAT-cycle multiplier and an output scoreboard.
module tb_mul_issue_ctrl;
  localparam int LAT   = 4;
  localparam int DEPTH = 4;
  localparam int MI    = (LAT >= 2) ? LAT - 2 : 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_a;
  logic [3:0]  in_b;
  logic [3:0]  mul_a;
  logic [3:0]  mul_b;
  logic [7:0]  mul_p;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_p;
  logic [3:0]  inflight;
  logic [11:0] acc;
  logic        acc_clr;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  mul_issue_ctrl #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
    .inflight(inflight), .acc(acc), .acc_clr(acc_clr)
  );

  // Downstream multiplier: product of the operand registers, visible LAT edges after they load.
  logic [7:0] prod0;
  logic [7:0] mreg [LAT];
  assign prod0 = {4'd0, mul_a} * {4'd0, mul_b};
  always @(posedge clk) begin
    mreg[0] <= prod0;
    for (int k = 1; k < LAT; k++) mreg[k] <= mreg[k-1];
  end
  assign mul_p = (LAT == 1) ? prod0 : mreg[MI];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) exp_q.push_back({4'd0, in_a} * {4'd0, in_b});
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL out_unexpected: observed out_p %0d expected no output", out_p);
      end else begin
        chk("out_p_order", out_p, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $error("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  logic [3:0] a2 [4] = '{4'd15, 4'd0, 4'd7, 4'd1};
  logic [3:0] b2 [4] = '{4'd15, 4'd9, 4'd8, 4'd1};
  logic [3:0] a3 [6] = '{4'd2, 4'd3, 4'd5, 4'd9, 4'd11, 4'd13};
  logic [3:0] b3 [6] = '{4'd7, 4'd6, 4'd4, 4'd10, 4'd12, 4'd14};

  initial begin
    int  idx;
    int  cyc;
    logic rdy_s;
    logic seen;

    in_valid = 0; in_a = 0; in_b = 0; out_ready = 1; acc_clr = 0; rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_p", out_p, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_acc", acc, 0);
    rst_n = 1;
    #1;
    chk("release_in_ready", in_ready, 1);

    // Single pair: result visible LAT edges after the accept edge.
    in_a = 4; in_b = 3; in_valid = 1;
    tick();
    in_valid = 0; in_a = 9; in_b = 9;
    chk("t1_mul_a", mul_a, 4);
    chk("t1_mul_b", mul_b, 3);
    chk("t1_inflight", inflight, 1);
    for (int k = 1; k <= LAT; k++) begin
      tick();
      chk("t1_out_valid", out_valid, (k == LAT) ? 1 : 0);
      if (k == LAT) chk("t1_out_p", out_p, 12);
    end
    tick();
    chk("t1_drained", out_valid, 0);
    chk("t1_inflight_end", inflight, 0);

    // Back-to-back stream with consumer always ready.
    for (int i = 0; i < 4; i++) begin
      in_a = a2[i]; in_b = b2[i]; in_valid = 1;
      chk("t2_in_ready", in_ready, 1);
      tick();
    end
    in_valid = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t2_out_valid_run", out_valid, 1);
    end
    tick();
    chk("t2_out_valid_end", out_valid, 0);
    chk("t2_sb_empty", exp_q.size(), 0);

    // Consumer stalled: only DEPTH pairs may be accepted.
    out_ready = 0;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      if (idx < 6) begin in_a = a3[idx]; in_b = b3[idx]; in_valid = 1; end
      else in_valid = 0;
      rdy_s = in_ready;
      tick();
      if (rdy_s && in_valid) idx++;
    end
    chk("t3_accepted", idx, DEPTH);
    chk("t3_in_ready_low", in_ready, 0);
    chk("t3_inflight", inflight, 0);
    chk("t3_out_valid", out_valid, 1);
    chk("t3_head", out_p, 14);
    out_ready = 1;
    cyc = 0;
    while (cyc < 40 && !(idx == 6 && exp_q.size() == 0)) begin
      if (idx < 6) begin in_a = a3[idx]; in_b = b3[idx]; in_valid = 1; end
      else in_valid = 0;
      rdy_s = in_ready;
      tick();
      if (rdy_s && in_valid) idx++;
      cyc++;
    end
    in_valid = 0;
    chk("t3_all_accepted", idx, 6);
    chk("t3_sb_empty", exp_q.size(), 0);

    // Reset with three products in flight.
    for (int i = 0; i < 3; i++) begin
      in_a = 4'(i + 3); in_b = 4'(i + 3); in_valid = 1;
      tick();
    end
    in_valid = 0;
    chk("t4_inflight_pre", inflight, 3);
    rst_n = 0;
    #1;
    chk("t4_rst_out_valid", out_valid, 0);
    chk("t4_rst_inflight", inflight, 0);
    chk("t4_rst_in_ready", in_ready, 0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out_valid) seen = 1;
    end
    chk("t4_no_stale", seen, 0);
    chk("t4_in_ready", in_ready, 1);

`ifdef MUL_ISSUE_ACC_EN
    chk("t5_acc_reset", acc, 0);
    for (int i = 0; i < 2; i++) begin
      in_a = 15; in_b = 15; in_valid = 1;
      tick();
    end
    in_valid = 0;
    repeat (LAT + 3) tick();
    chk("t5_acc_sum", acc, 450);
    in_a = 4; in_b = 3; in_valid = 1;
    tick();
    in_valid = 0;
    repeat (LAT - 1) tick();
    acc_clr = 1;
    tick();
    acc_clr = 0;
    chk("t5_acc_clr_wins", acc, 0);
    chk("t5_clr_out_p", out_p, 12);
    repeat (3) tick();
    chk("t5_acc_after", acc, 0);
`else
    acc_clr = 1;
    in_a = 15; in_b = 15; in_valid = 1;
    tick();
    in_valid = 0;
    acc_clr = 0;
    repeat (LAT + 3) tick();
    chk("t5_acc_tied", acc, 0);
`endif

    chk("final_sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
